// File: rtl/tv80_wait_decode.sv
// Address decoder and wait-state generator for the TV80 bus: programmable memory/IO regions,
// per-region rd/wr selects, per-region wait-state insertion and a saturating unmapped-access counter.
module tv80_wait_decode #(
  parameter int unsigned            NREG      = 4,
  parameter int unsigned            WAIT_W    = 3,
  parameter logic [16*NREG-1:0]     REG_BASE  = 64'h0008_4000_8000_0000,
  parameter logic [16*NREG-1:0]     REG_MASK  = 64'h00F8_C000_8000_F000,
  parameter logic [NREG-1:0]        REG_IO    = 4'b0000,
  parameter logic [WAIT_W*NREG-1:0] REG_WAITS = 12'h000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mreq_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic            m1_n,
  input  logic            rfsh_n,
  input  logic [15:0]     A,
  input  logic            ext_wait_n,
  output logic [NREG-1:0] rd_cs,
  output logic [NREG-1:0] wr_cs,
  output logic            wait_n,
  output logic            miss,
  output logic [7:0]      miss_cnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_acc_q;
  logic              r_wait_n_q;
  logic              r_miss;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic              w_acc;
  logic              w_start;
  logic              w_any;
  logic [NREG-1:0]   w_hit;
  logic [NREG-1:0]   w_sel;
  logic [WAIT_W-1:0] w_waits;

  // Interrupt acknowledge and refresh cycles are never decoded.
  assign w_acc = rfsh_n & ~(~m1_n & ~iorq_n) & (~rd_n | ~wr_n) & (~mreq_n | ~iorq_n);

  // Per-region match; IO regions only look at the low address byte.
  always_comb begin : hit_decode
    w_hit = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      if (REG_IO[r]) begin
        w_hit[r] = w_acc & ~iorq_n &
                   ((A[7:0] & REG_MASK[16*r +: 8]) == (REG_BASE[16*r +: 8] & REG_MASK[16*r +: 8]));
      end else begin
        w_hit[r] = w_acc & ~mreq_n &
                   ((A & REG_MASK[16*r +: 16]) == (REG_BASE[16*r +: 16] & REG_MASK[16*r +: 16]));
      end
    end
  end

  // Lowest-index hit wins; scanning downwards lets the last assignment be the winner.
  always_comb begin : prio_select
    w_sel   = '0;
    w_waits = '0;
    for (int r = int'(NREG) - 1; r >= 0; r--) begin
      if (w_hit[r]) begin
        w_sel    = '0;
        w_sel[r] = 1'b1;
        w_waits  = REG_WAITS[r*WAIT_W +: WAIT_W];
      end
    end
  end

  assign w_any   = |w_hit;
  assign w_start = w_acc & ~r_acc_q;

  assign rd_cs    = w_sel & {NREG{~rd_n}};
  assign wr_cs    = w_sel & {NREG{~wr_n}};
  assign wait_n   = r_wait_n_q & ext_wait_n;
  assign miss     = r_miss;
  assign miss_cnt = r_miss_cnt;

  // Access sequencer: wait_n_q mirrors (next state != WAIT).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc_q    <= 1'b0;
      r_wait_n_q <= 1'b1;
      r_miss     <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      r_acc_q <= w_acc;
      r_miss  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (!w_any) begin
              r_state <= ST_HOLD;
              r_miss  <= 1'b1;
              if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end else if (w_waits != '0) begin
              r_cnt      <= w_waits - WAIT_W'(1);
              r_state    <= ST_WAIT;
              r_wait_n_q <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          if (!w_acc) begin
            r_state    <= ST_IDLE;
            r_wait_n_q <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state    <= ST_HOLD;
            r_wait_n_q <= 1'b1;
          end else begin
            r_cnt <= r_cnt - WAIT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!w_acc) r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_n_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv80_wait_decode.sv
// Directed bench for tv80_wait_decode: a general map (u_a) and an overlapping map (u_b).
module tb_tv80_wait_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, ext_wait_n;
  logic [15:0] A;

  logic [3:0]  a_rd_cs, a_wr_cs, b_rd_cs, b_wr_cs;
  logic        a_wait_n, b_wait_n, a_miss, b_miss;
  logic [7:0]  a_miss_cnt, b_miss_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // r0 mem 0000-0FFF w0, r1 mem 8000-FFFF w3, r2 mem 4000-7FFF w1, r3 IO 08-0F w0
  tv80_wait_decode #(
    .NREG(4), .WAIT_W(3),
    .REG_BASE ({16'h0008, 16'h4000, 16'h8000, 16'h0000}),
    .REG_MASK ({16'h00F8, 16'hC000, 16'h8000, 16'hF000}),
    .REG_IO   (4'b1000),
    .REG_WAITS({3'd0, 3'd1, 3'd3, 3'd0})
  ) u_a (
    .clk(clk), .reset_n(reset_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .ext_wait_n(ext_wait_n),
    .rd_cs(a_rd_cs), .wr_cs(a_wr_cs), .wait_n(a_wait_n), .miss(a_miss), .miss_cnt(a_miss_cnt)
  );

  // r0 matches everything, r2 covers 8000-FFFF: r0 must win on overlap.
  tv80_wait_decode #(
    .NREG(4), .WAIT_W(3),
    .REG_BASE ({16'h0000, 16'h8000, 16'h4000, 16'h0000}),
    .REG_MASK ({16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000}),
    .REG_IO   (4'b0000),
    .REG_WAITS(12'h000)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .ext_wait_n(ext_wait_n),
    .rd_cs(b_rd_cs), .wr_cs(b_wr_cs), .wait_n(b_wait_n), .miss(b_miss), .miss_cnt(b_miss_cnt)
  );

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; rfsh_n = 1'b1; ext_wait_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    // Unmapped access to bump miss_cnt
    step(); A = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if (a_miss_cnt === 8'd1) n_pass++; else $display("FAIL reset_pre_cnt: got %0d expected 1", a_miss_cnt);
    step(); bus_idle();
    step();
    // Enter WAIT on region1, then reset mid-wait
    A = 16'h8004; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if (a_wait_n === 1'b0) n_pass++; else $display("FAIL reset_in_wait: got %b expected 0", a_wait_n);
    step(); reset_n = 1'b0; bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL reset_wait_n: got %b expected 1", a_wait_n);
    n_total++; if (a_miss_cnt === 8'd0) n_pass++; else $display("FAIL reset_miss_cnt: got %0d expected 0", a_miss_cnt);
    n_total++; if (a_miss === 1'b0) n_pass++; else $display("FAIL reset_miss: got %b expected 0", a_miss);
    n_total++; if (a_rd_cs === 4'b0000) n_pass++; else $display("FAIL reset_rd_cs: got %b expected 0000", a_rd_cs);
    step(); reset_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL reset_after: got %b expected 1", a_wait_n);
  endtask

  task automatic test_mem_wait();
    logic exp_w;
    step(); A = 16'h8004; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_rd_cs === 4'b0010) n_pass++; else $display("FAIL mem_rd_cs: got %b expected 0010", a_rd_cs);
    n_total++; if (a_wr_cs === 4'b0000) n_pass++; else $display("FAIL mem_wr_cs: got %b expected 0000", a_wr_cs);
    n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL mem_wait_pre: got %b expected 1", a_wait_n);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_w = (i <= 3) ? 1'b0 : 1'b1;
      n_total++;
      if (a_wait_n === exp_w) n_pass++;
      else $display("FAIL mem_wait_clk%0d: got %b expected %b", i, a_wait_n, exp_w);
    end
    step(); bus_idle();
    step();
  endtask

  task automatic test_overlap();
    step(); A = 16'h9000; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    n_total++; if (b_wr_cs === 4'b0001) n_pass++; else $display("FAIL overlap_wr_cs: got %b expected 0001", b_wr_cs);
    n_total++; if (b_rd_cs === 4'b0000) n_pass++; else $display("FAIL overlap_rd_cs: got %b expected 0000", b_rd_cs);
    n_total++; if (a_wr_cs === 4'b0010) n_pass++; else $display("FAIL overlap_a_wr_cs: got %b expected 0010", a_wr_cs);
    repeat (5) step();
    bus_idle();
    step();
  endtask

  task automatic test_io();
    step(); A = 16'h550A; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_wr_cs === 4'b1000) n_pass++; else $display("FAIL io_wr_cs: got %b expected 1000", a_wr_cs);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL io_wait_clk%0d: got %b expected 1", i, a_wait_n);
    end
    n_total++; if (a_miss_cnt === 8'd0) n_pass++; else $display("FAIL io_miss_cnt: got %0d expected 0", a_miss_cnt);
    step(); bus_idle();
    step();
    // Interrupt acknowledge to the same port must be ignored
    A = 16'h000A; m1_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_rd_cs === 4'b0000) n_pass++; else $display("FAIL intack_rd_cs: got %b expected 0000", a_rd_cs);
    n_total++; if (a_wr_cs === 4'b0000) n_pass++; else $display("FAIL intack_wr_cs: got %b expected 0000", a_wr_cs);
    @(negedge clk);
    n_total++; if (a_miss === 1'b0) n_pass++; else $display("FAIL intack_miss: got %b expected 0", a_miss);
    n_total++; if (a_miss_cnt === 8'd0) n_pass++; else $display("FAIL intack_miss_cnt: got %0d expected 0", a_miss_cnt);
    step(); bus_idle();
    step();
  endtask

  task automatic test_refresh();
    step(); A = 16'h8004; rfsh_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_rd_cs === 4'b0000) n_pass++; else $display("FAIL rfsh_rd_cs: got %b expected 0000", a_rd_cs);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL rfsh_wait_clk%0d: got %b expected 1", i, a_wait_n);
    end
    n_total++; if (a_miss_cnt === 8'd0) n_pass++; else $display("FAIL rfsh_miss_cnt: got %0d expected 0", a_miss_cnt);
    step(); bus_idle();
    step();
  endtask

  task automatic test_ext_wait();
    step(); A = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_rd_cs === 4'b0001) n_pass++; else $display("FAIL ext_rd_cs: got %b expected 0001", a_rd_cs);
    step(); ext_wait_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b0) n_pass++; else $display("FAIL ext_wait_clk1: got %b expected 0", a_wait_n);
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b0) n_pass++; else $display("FAIL ext_wait_clk2: got %b expected 0", a_wait_n);
    step(); ext_wait_n = 1'b1;
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL ext_wait_release: got %b expected 1", a_wait_n);
    step(); bus_idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_w;
    // Region2, one wait state
    step(); A = 16'h4010; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_rd_cs === 4'b0100) n_pass++; else $display("FAIL b2b_r2_rd_cs: got %b expected 0100", a_rd_cs);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_w = (i == 1) ? 1'b0 : 1'b1;
      n_total++;
      if (a_wait_n === exp_w) n_pass++;
      else $display("FAIL b2b_r2_wait_clk%0d: got %b expected %b", i, a_wait_n, exp_w);
    end
    step(); bus_idle();
    // One idle clock, then a region1 write with three waits
    step(); A = 16'hC000; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    n_total++; if (a_wr_cs === 4'b0010) n_pass++; else $display("FAIL b2b_r1_wr_cs: got %b expected 0010", a_wr_cs);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp_w = (i <= 3) ? 1'b0 : 1'b1;
      n_total++;
      if (a_wait_n === exp_w) n_pass++;
      else $display("FAIL b2b_r1_wait_clk%0d: got %b expected %b", i, a_wait_n, exp_w);
    end
    step(); bus_idle();
    step();
  endtask

  task automatic test_miss();
    for (int k = 1; k <= 260; k++) begin
      step(); A = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      @(negedge clk); @(negedge clk);
      n_total++; if (a_miss === 1'b1) n_pass++; else $display("FAIL miss_pulse_%0d: got %b expected 1", k, a_miss);
      n_total++;
      if (a_miss_cnt === 8'(exp_cnt)) n_pass++;
      else $display("FAIL miss_cnt_%0d: got %0d expected %0d", k, a_miss_cnt, exp_cnt);
      @(negedge clk);
      n_total++; if (a_miss === 1'b0) n_pass++; else $display("FAIL miss_clear_%0d: got %b expected 0", k, a_miss);
      step(); bus_idle();
    end
    step();
    n_total++; if (a_miss_cnt === 8'hFF) n_pass++; else $display("FAIL miss_sat: got %h expected ff", a_miss_cnt);
  endtask

  initial begin
    reset_n = 1'b0;
    A = 16'h0000;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (a_wait_n === 1'b1) n_pass++; else $display("FAIL init_wait_n: got %b expected 1", a_wait_n);
    n_total++; if (a_miss_cnt === 8'd0) n_pass++; else $display("FAIL init_miss_cnt: got %0d expected 0", a_miss_cnt);
    test_reset();
    test_mem_wait();
    test_overlap();
    test_io();
    test_refresh();
    test_ext_wait();
    test_back_to_back();
    test_miss();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
